// File: rtl/tdm_frame_deser_if.sv
// Parallel sample-word stream out of the TDM deserializer: head-of-FIFO word,
// its channel tag and frame-last marker, under valid/ready flow control.
interface tdm_frame_deser_if #(
  parameter int SAMPLE_W = 24,
  parameter int CH_W     = 3
);
  logic [SAMPLE_W-1:0] out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/tdm_frame_deser.sv
// First-word fall-through FIFO; head entry visible combinationally.
// Latency: write to head visibility is 0 cycles after the push edge.
// Backpressure: a push while full is accepted only if a pop happens the same cycle.
module tdm_frame_deser_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Rebuilds the serial TDM chain output into per-channel words, MSB first, channel 0 first.
// Latency: a word reaches out_valid on the same edge that samples its LSB (FIFO empty).
// Backpressure: FIFO absorbs stalls; a word completed while full is dropped and flagged.
module tdm_frame_deser #(
  parameter int N_CH       = 8,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic lr_clk,
  input  logic serial_in,
  input  logic clear_flags,
  output logic overflow,
  output logic frame_err,
  tdm_frame_deser_if.master out
);
  localparam int BW = $clog2(SAMPLE_W);
  localparam int FW = SAMPLE_W + CH_W + 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(SAMPLE_W - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t              state, state_n;
  logic                lr_prev;
  logic                lr_rise;
  logic [BW-1:0]       bit_cnt, bit_cnt_n;
  logic [CH_W-1:0]     ch_cnt, ch_cnt_n;
  logic [SAMPLE_W-2:0] shreg, shreg_n;
  logic [SAMPLE_W-1:0] word_n;
  logic                push_req;
  logic                ferr_set;
  logic                ovf_set;
  logic                pop_fire;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       push_dat;
  logic [FW-1:0]       head_dat;

  assign lr_rise  = lr_clk & ~lr_prev;
  assign word_n   = {shreg, serial_in};
  assign push_dat = {(ch_cnt == LAST_CH), ch_cnt, word_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lr_prev <= 1'b1;
      bit_cnt <= '0;
      ch_cnt  <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      lr_prev <= lr_clk;
      bit_cnt <= bit_cnt_n;
      ch_cnt  <= ch_cnt_n;
      shreg   <= shreg_n;
    end
  end

  // A rising frame clock always restarts at channel 0 with this cycle's bit as the MSB;
  // inside CAPTURE that means the running frame was cut short.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    ch_cnt_n  = ch_cnt;
    shreg_n   = shreg;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (lr_rise) begin
          state_n   = CAPTURE;
          bit_cnt_n = BW'(1);
          ch_cnt_n  = '0;
          shreg_n   = word_n[SAMPLE_W-2:0];
        end
      end
      CAPTURE: begin
        shreg_n = word_n[SAMPLE_W-2:0];
        if (lr_rise) begin
          ferr_set  = 1'b1;
          bit_cnt_n = BW'(1);
          ch_cnt_n  = '0;
        end else if (bit_cnt == LAST_BIT) begin
          push_req  = 1'b1;
          bit_cnt_n = '0;
          if (ch_cnt == LAST_CH) begin
            ch_cnt_n = '0;
            state_n  = DONE;
          end else begin
            ch_cnt_n = ch_cnt + 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop_fire = out.out_ready & ~fifo_empty;
  assign ovf_set  = push_req & fifo_full & ~pop_fire;

  tdm_frame_deser_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_dat (push_dat),
    .pop      (out.out_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {out.out_last, out.out_ch, out.out_data} = head_dat;
  assign out.out_valid = ~fifo_empty;

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_set  | (overflow  & ~clear_flags);
      frame_err <= ferr_set | (frame_err & ~clear_flags);
    end
  end
endmodule
